// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature step generator:
// FSM encoding, datapath widths and the clockwise Gray sequence.
package quad_pkg;

    localparam int COUNT_W  = 8;
    localparam int PERIOD_W = 16;
    localparam int POS_W    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Index into the Gray table; stepping +1 walks CW, -1 walks CCW.
    typedef logic [1:0] phase_t;

    // (a,b) for each phase index, CW order: 00 -> 10 -> 11 -> 01 -> 00.
    localparam logic [1:0] GRAY_CW [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // A zero period is treated as one clock between transitions.
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

    function automatic phase_t phase_step(input phase_t ph, input logic cw);
        return cw ? phase_t'(ph + 2'd1) : phase_t'(ph - 2'd1);
    endfunction

endpackage

// File: rtl/quad_gen_if.sv
// Command channel of quad_gen: a valid/ready step request plus an abort line.
// The master offers commands, the slave (quad_gen) accepts them.
interface quad_gen_if;
    import quad_pkg::*;

    logic                cmd_valid;
    logic                cmd_dir;
    logic [COUNT_W-1:0]  cmd_count;
    logic [PERIOD_W-1:0] cmd_period;
    logic                cmd_ready;
    logic                cmd_abort;

    modport master (
        output cmd_valid, cmd_dir, cmd_count, cmd_period, cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_count, cmd_period, cmd_abort,
        output cmd_ready
    );

endinterface

// File: rtl/quad_step_timer.sv
// Inter-transition timer: loads a period, counts down and raises a
// one-cycle tick on expiry, then reloads the same period until cleared.
module quad_step_timer
    import quad_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] reload_q;

    // A count of zero means idle, so the tick fires only while armed.
    assign tick = (count_q == PERIOD_W'(1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
        end else if (clear) begin
            count_q  <= '0;
        end else if (load) begin
            count_q  <= period;
            reload_q <= period;
        end else if (tick) begin
            count_q  <= reload_q;
        end else if (count_q != '0) begin
            count_q  <= count_q - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/quad_gen.sv
// Quadrature step generator: emits count Gray-coded transitions on enc_a/enc_b,
// one every period clocks, tracking net position and pulsing done on completion.
module quad_gen
    import quad_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    quad_gen_if.slave        cmd,
    output logic             enc_a,
    output logic             enc_b,
    output logic [POS_W-1:0] position,
    output logic             done
);

    state_t state_q, state_d;

    logic ready;
    logic load;
    logic tick;
    logic step;
    logic last_step;
    logic timer_clear;

    logic                dir_q;
    logic [COUNT_W-1:0]  remaining_q;
    phase_t              phase_q;
    phase_t              phase_nxt;
    logic [POS_W-1:0]    pos_q;
    logic                enc_a_q, enc_b_q;
    logic                done_q;

    quad_step_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .clear  (timer_clear),
        .period (eff_period(cmd.cmd_period)),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd.cmd_valid && cmd.cmd_count != '0) state_d = ST_RUN;
            ST_RUN:  if (cmd.cmd_abort || last_step)          state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        ready       = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        last_step   = 1'b0;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                load  = cmd.cmd_valid && (cmd.cmd_count != '0);
            end
            ST_RUN: begin
                // Abort beats a coincident tick: that transition never happens.
                step        = tick && !cmd.cmd_abort;
                last_step   = step && (remaining_q == COUNT_W'(1));
                timer_clear = cmd.cmd_abort || last_step;
            end
            default: ;
        endcase
    end

    assign phase_nxt = phase_step(phase_q, dir_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q       <= 1'b0;
            remaining_q <= '0;
            phase_q     <= '0;
            pos_q       <= '0;
            enc_a_q     <= 1'b0;
            enc_b_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= last_step;
            if (load) begin
                dir_q       <= cmd.cmd_dir;
                remaining_q <= cmd.cmd_count;
            end else if (state_q == ST_RUN && cmd.cmd_abort) begin
                remaining_q <= '0;
            end else if (step) begin
                remaining_q        <= remaining_q - COUNT_W'(1);
                phase_q            <= phase_nxt;
                {enc_a_q, enc_b_q} <= GRAY_CW[phase_nxt];
                pos_q              <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            end
        end
    end

    assign cmd.cmd_ready = ready;
    assign enc_a         = enc_a_q;
    assign enc_b         = enc_b_q;
    assign position      = pos_q;
    assign done          = done_q;

endmodule

// File: doc/quad_gen.md
QUAD_GEN -- requirements
Module: quad_gen

Interface
REQ-001 quad_gen SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Port clk: input, 1 bit, sole clock, all state updates on its rising edge.
REQ-003 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-004 Port cmd_valid: input, 1 bit, step command offered.
REQ-005 Port cmd_dir: input, 1 bit, direction: 1 = CW (A leads B), 0 = CCW.
REQ-006 Port cmd_count: input, 8 bits, number of quadrature transitions to emit.
REQ-007 Port cmd_period: input, 16 bits, clk cycles between transitions.
REQ-008 Port cmd_ready: output, 1 bit, command can be accepted this cycle.
REQ-009 Port cmd_abort: input, 1 bit, synchronous cancel of the active command.
REQ-010 Port enc_a, enc_b: output, 1 bit each, quadrature pair for an encoder/debounce receiver.
REQ-011 Port position: output, 8 bits, net transition count, CW +1, CCW -1, modulo 256.
REQ-012 Port done: output, 1 bit, single-cycle pulse when a command completes normally.

Function
REQ-013 States SHALL be IDLE and RUN; cmd_ready SHALL be 1 exactly in IDLE.
REQ-014 Acceptance SHALL occur at an edge where cmd_valid && cmd_ready; dir, count and period latch there; later input changes are ignored until the next acceptance.
REQ-015 Accepted cmd_count = 0 SHALL be a no-op: stay IDLE, no transition, no done pulse.
REQ-016 Accepted cmd_period = 0 SHALL behave as period 1.
REQ-017 For acceptance at edge T with count N >= 1 and period P, transitions SHALL occur at edges T+P, T+2P, ... T+N*P, and at no other edges.
REQ-018 Each transition SHALL change exactly one of enc_a/enc_b; CW sequence (a,b): 00->10->11->01->00; CCW is the exact reverse.
REQ-019 The Gray phase SHALL persist across commands; a new command continues from the current (a,b).
REQ-020 position SHALL update on the same edge as each transition; it wraps 255->0 (CW) and 0->255 (CCW).
REQ-021 At edge T+N*P the FSM SHALL return to IDLE, and done SHALL be 1 for exactly the following cycle.
REQ-022 Earliest next acceptance SHALL be edge T+N*P+1; back-to-back spacing is therefore P+1 cycles.
REQ-023 cmd_abort high at an edge in RUN SHALL return the FSM to IDLE with no transition at that edge and no done pulse; enc_a, enc_b and position hold.
REQ-024 cmd_abort in IDLE SHALL have no effect and SHALL NOT block an acceptance at the same edge.
REQ-025 If cmd_abort coincides with a scheduled transition, abort wins and the transition SHALL be suppressed.

Reset
REQ-026 reset SHALL force, asynchronously: state IDLE, enc_a=0, enc_b=0, position=0, done=0, cmd_ready=1, timer and remaining count 0.
REQ-027 reset asserted mid-command SHALL discard the command; no done pulse follows deassertion.
REQ-028 After reset deassertion, the first edge with cmd_valid high SHALL accept a command.

Structure
REQ-029 Package quad_pkg SHALL hold the state encoding, the CW Gray sequence constants, and widths (COUNT_W=8, PERIOD_W=16, POS_W=8).
REQ-030 The inter-transition timer SHALL be a sub-module quad_step_timer: load P, count down, single-cycle tick on expiry, clear on abort or reset.
REQ-031 Estimated implementation size is 120-400 RTL lines.

Verification
REQ-032 Reset, then CW N=4, P=3 accepted at edge 0 -> (a,b) 10,11,01,00 at edges 3,6,9,12; position 4; done high during cycle after edge 12.
REQ-033 CCW N=2, P=1 from position 0, phase 00 -> (a,b) 01 at edge 1, 11 at edge 2; position 254; done once.
REQ-034 cmd_count=0 and cmd_period=0 commands -> count 0: no transition, no done; period 0 with N=3: transitions on 3 consecutive edges.
REQ-035 CW N=10, P=5, cmd_abort at edge 12 -> exactly 2 transitions; outputs hold at 11; cmd_ready high after edge 12; no done.
REQ-036 reset pulsed mid-command (CW N=8, P=2, at cycle 7) -> outputs 00, position 0 immediately; no further transitions or done.
REQ-037 Two back-to-back CW N=1, P=4 commands -> transitions 5 cycles apart; a receiving encoder model increments position by 2.
